tile_draw_scheduler: RTL and testbench

Sequences the display command LUT (`command_lut`) to initialize the panel and then redraw individual 20x20-pixel tiles on request. Upstream game logic pushes tile updates (X, Y, obj_code) into a small internal FIFO. The block drives the LUT's `mode`, `X`, `Y` and `obj_code` inputs and generates the panel write strobe `wrx` and chip select `csx`. It sits between the game-state logic and `command_lut`, which feeds the 8080-style panel bus.

---
 rtl/tile_draw_scheduler_pkg.sv | 20 ++
 rtl/tile_draw_scheduler_fifo.sv | 56 +++++
 rtl/tile_draw_scheduler.sv | 141 ++++++++++++++
 tb/tb_tile_draw_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_draw_scheduler_pkg.sv
// Shared display types: the command LUT mode and the packed tile-update request.
package tile_draw_scheduler_pkg;

  typedef enum logic [2:0] {
    NONE   = 3'd0,
    SET_I  = 3'd1,
    SEND_I = 3'd2,
    SET    = 3'd3,
    SEND   = 3'd4
  } update_t;

  typedef struct packed {
    logic [2:0] obj;
    logic [3:0] y;
    logic [3:0] x;
  } tile_req_t;

  localparam int unsigned TILE_REQ_W = $bits(tile_req_t);

endpackage

// File: rtl/tile_draw_scheduler_fifo.sv
// Small request FIFO: wrapping read/write pointers plus an occupancy count.
module tile_req_fifo
  import tile_draw_scheduler_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = TILE_REQ_W
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/tile_draw_scheduler.sv
// Drives command_lut through panel init and then per-tile redraws taken from a request FIFO.
module tile_draw_scheduler
  import tile_draw_scheduler_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PWR_DLY = 100
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       init_req,
  input  logic       req_valid,
  input  logic [3:0] req_x,
  input  logic [3:0] req_y,
  input  logic [2:0] req_obj,
  output logic       req_ready,
  input  logic       cmd_finished,
  input  logic       pause,
  output update_t    mode,
  output logic [3:0] X,
  output logic [3:0] Y,
  output logic [2:0] obj_code,
  output logic       wrx,
  output logic       csx,
  output logic       busy,
  output logic       init_done
);

  typedef enum logic [2:0] {
    PWR_WAIT, INIT_SET, INIT_SEND, IDLE, LOAD, DRAW_SET, DRAW_SEND
  } state_t;

  localparam int DLY_W = (PWR_DLY > 1) ? $clog2(PWR_DLY) : 1;

  state_t           state_q, state_d;
  update_t          mode_q, mode_d;
  logic [3:0]       x_q, x_d, y_q, y_d;
  logic [2:0]       obj_q, obj_d;
  logic             wrx_q, wrx_d, csx_q, csx_d, busy_q, busy_d;
  logic             init_done_q, init_done_d;
  logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;

  tile_req_t fifo_din, fifo_head;
  logic      fifo_full, fifo_empty, fifo_push, fifo_pop;

  assign req_ready = ~fifo_full;
  assign fifo_push = req_valid & req_ready;
  assign fifo_pop  = (state_q == LOAD);
  assign fifo_din  = '{obj: req_obj, y: req_y, x: req_x};

  tile_req_fifo #(.DEPTH(DEPTH), .WIDTH(TILE_REQ_W)) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    dly_cnt_d   = dly_cnt_q;
    init_done_d = init_done_q;
    x_d         = x_q;
    y_d         = y_q;
    obj_d       = obj_q;

    case (state_q)
      PWR_WAIT:  if (dly_cnt_q == DLY_W'(PWR_DLY - 1)) state_d = INIT_SET;
                 else dly_cnt_d = dly_cnt_q + DLY_W'(1);
      INIT_SET:  if (!pause) state_d = INIT_SEND;
      INIT_SEND: if (cmd_finished) begin
                   init_done_d = 1'b1;
                   state_d     = IDLE;
                 end else state_d = INIT_SET;
      IDLE:      if (init_req) state_d = INIT_SET;
                 else if (!fifo_empty) state_d = LOAD;
      LOAD:      state_d = DRAW_SET;
      DRAW_SET:  state_d = DRAW_SEND;
      DRAW_SEND: if (cmd_finished) state_d = fifo_empty ? IDLE : LOAD;
                 else state_d = DRAW_SET;
      default:   state_d = PWR_WAIT;
    endcase

    // The head being popped in LOAD is latched on entry so X/Y/obj_code hold it all tile long.
    if (state_d == LOAD) begin
      x_d   = fifo_head.x;
      y_d   = fifo_head.y;
      obj_d = fifo_head.obj;
    end

    mode_d = NONE;
    wrx_d  = 1'b1;
    csx_d  = 1'b1;
    busy_d = (state_d != IDLE);
    case (state_d)
      INIT_SET:  begin mode_d = SET_I;  wrx_d = 1'b0; csx_d = 1'b0; end
      INIT_SEND: begin mode_d = SEND_I; csx_d = 1'b0; end
      DRAW_SET:  begin mode_d = SET;    wrx_d = 1'b0; csx_d = 1'b0; end
      DRAW_SEND: begin mode_d = SEND;   csx_d = 1'b0; end
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= PWR_WAIT;
      dly_cnt_q   <= '0;
      init_done_q <= 1'b0;
      mode_q      <= NONE;
      wrx_q       <= 1'b1;
      csx_q       <= 1'b1;
      busy_q      <= 1'b1;
      x_q         <= '0;
      y_q         <= '0;
      obj_q       <= '0;
    end else begin
      state_q     <= state_d;
      dly_cnt_q   <= dly_cnt_d;
      init_done_q <= init_done_d;
      mode_q      <= mode_d;
      wrx_q       <= wrx_d;
      csx_q       <= csx_d;
      busy_q      <= busy_d;
      x_q         <= x_d;
      y_q         <= y_d;
      obj_q       <= obj_d;
    end
  end

  assign mode      = mode_q;
  assign X         = x_q;
  assign Y         = y_q;
  assign obj_code  = obj_q;
  assign wrx       = wrx_q;
  assign csx       = csx_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_tile_draw_scheduler.sv
// Directed bench for tile_draw_scheduler with a stub command LUT driving pause/cmd_finished.
module tb_tile_draw_scheduler;
  import tile_draw_scheduler_pkg::*;

  localparam int DEPTH   = 4;
  localparam int PWR_DLY = 10;

  logic       clk = 1'b0;
  logic       nrst, init_req, req_valid;
  logic [3:0] req_x, req_y;
  logic [2:0] req_obj;
  logic       req_ready, cmd_finished, pause;
  update_t    mode;
  logic [3:0] X, Y;
  logic [2:0] obj_code;
  logic       wrx, csx, busy, init_done;

  tile_draw_scheduler #(.DEPTH(DEPTH), .PWR_DLY(PWR_DLY)) dut (
    .clk(clk), .nrst(nrst), .init_req(init_req), .req_valid(req_valid),
    .req_x(req_x), .req_y(req_y), .req_obj(req_obj), .req_ready(req_ready),
    .cmd_finished(cmd_finished), .pause(pause), .mode(mode), .X(X), .Y(Y),
    .obj_code(obj_code), .wrx(wrx), .csx(csx), .busy(busy), .init_done(init_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stub LUT: counts SEND cycles per command, pauses on the 2nd init byte when enabled.
  int   send_cnt  = 0;
  int   pause_cyc = 0;
  int   init_n    = 4;
  int   draw_n    = 14;
  logic pause_en  = 1'b0;

  always @(posedge clk) begin
    if (mode == NONE) begin
      send_cnt  <= 0;
      pause_cyc <= 0;
    end else begin
      if (mode == SEND_I || mode == SEND) send_cnt <= send_cnt + 1;
      if (pause) pause_cyc <= pause_cyc + 1;
    end
  end

  assign pause        = pause_en && (mode == SET_I) && (send_cnt == 1) && (pause_cyc < 5);
  assign cmd_finished = ((mode == SEND_I) && (send_cnt == init_n - 1)) ||
                        ((mode == SEND)   && (send_cnt == draw_n - 1));

  int          rise_cnt  = 0;
  logic        wrx_prev  = 1'b1;
  update_t     prev_mode = NONE;
  logic [10:0] log_q[$];

  always @(negedge clk) begin
    if (wrx === 1'b1 && wrx_prev === 1'b0) rise_cnt <= rise_cnt + 1;
    if (mode == SET && prev_mode == NONE) log_q.push_back({obj_code, Y, X});
    wrx_prev  <= wrx;
    prev_mode <= mode;
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [3:0] x, input logic [3:0] y, input logic [2:0] o);
    req_valid = 1'b1;
    req_x     = x;
    req_y     = y;
    req_obj   = o;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int steps);
    steps = 0;
    while (busy !== 1'b0 && steps < budget) begin
      step();
      steps++;
    end
  endtask

  function automatic logic [10:0] tile(input int x, input int y, input int o);
    return {3'(o), 4'(y), 4'(x)};
  endfunction

  function automatic logic [10:0] log_at(input int idx);
    if (idx < log_q.size()) return log_q[idx];
    return 11'h7ff;
  endfunction

  update_t exp_init [13] = '{SET_I, SEND_I, SET_I, SET_I, SET_I, SET_I, SET_I, SET_I,
                             SEND_I, SET_I, SEND_I, SET_I, SEND_I};

  initial begin
    int steps;
    int r0;
    int lb;
    logic [10:0] exp_t [5];

    nrst = 1'b0; init_req = 1'b0; req_valid = 1'b0;
    req_x = '0; req_y = '0; req_obj = '0;
    pause_en = 1'b1;
    step(3);
    check_eq("rst_mode", mode, NONE);
    check_eq("rst_wrx", wrx, 1);
    check_eq("rst_csx", csx, 1);
    check_eq("rst_xyo", {obj_code, Y, X}, 0);
    check_eq("rst_busy", busy, 1);
    check_eq("rst_init_done", init_done, 0);
    check_eq("rst_ready", req_ready, 1);

    nrst = 1'b1;
    step(9);
    check_eq("pwr_wait_mode", mode, NONE);
    step();
    for (int i = 0; i < 13; i++) begin
      check_eq($sformatf("init_mode_%0d", i), mode, exp_init[i]);
      check_eq($sformatf("init_wrx_%0d", i), wrx, (exp_init[i] == SEND_I) ? 1 : 0);
      check_eq($sformatf("init_csx_%0d", i), csx, 0);
      step();
    end
    check_eq("init_idle_mode", mode, NONE);
    check_eq("init_idle_busy", busy, 0);
    check_eq("init_done_set", init_done, 1);
    check_eq("init_idle_csx", csx, 1);
    pause_en = 1'b0;

    draw_n = 14;
    r0 = rise_cnt;
    push_req(4'd3, 4'd7, 3'd3);
    check_eq("tile_push_idle", busy, 0);
    step();
    check_eq("tile_load_busy", busy, 1);
    check_eq("tile_load_mode", mode, NONE);
    check_eq("tile_load_csx", csx, 1);
    step();
    check_eq("tile_set_mode", mode, SET);
    check_eq("tile_set_wrx", wrx, 0);
    check_eq("tile_set_csx", csx, 0);
    check_eq("tile_set_xyo", {obj_code, Y, X}, tile(3, 7, 3));
    wait_idle(100, steps);
    check_eq("tile_draw_cycles", steps, 28);
    check_eq("tile_wrx_rises", rise_cnt - r0, 14);
    check_eq("tile_end_csx", csx, 1);
    check_eq("tile_end_busy", busy, 0);
    check_eq("tile_end_xyo", {obj_code, Y, X}, tile(3, 7, 3));

    draw_n = 3;
    lb = log_q.size();
    push_req(4'd1, 4'd1, 3'd1);
    step(2);
    check_eq("full_first_set", mode, SET);
    push_req(4'd2, 4'd2, 3'd2);
    push_req(4'd3, 4'd3, 3'd3);
    push_req(4'd4, 4'd4, 3'd4);
    push_req(4'd5, 4'd5, 3'd5);
    check_eq("full_ready_low", req_ready, 0);
    push_req(4'd6, 4'd6, 3'd6);
    check_eq("full_drop_ready", req_ready, 0);
    wait_idle(200, steps);
    check_eq("full_no_gap_cycles", steps, 29);
    check_eq("full_tile_count", log_q.size() - lb, 5);
    for (int i = 0; i < 5; i++)
      check_eq($sformatf("full_order_%0d", i), log_at(lb + i), tile(i + 1, i + 1, i + 1));

    draw_n = 1;
    lb = log_q.size();
    exp_t[0] = tile(6, 1, 2);
    exp_t[1] = tile(7, 2, 4);
    exp_t[2] = tile(8, 3, 5);
    push_req(4'd6, 4'd1, 3'd2);
    push_req(4'd7, 4'd2, 3'd4);
    check_eq("pp_load_mode", mode, NONE);
    check_eq("pp_load_busy", busy, 1);
    check_eq("pp_count_before", dut.u_fifo.count_q, 2);
    push_req(4'd8, 4'd3, 3'd5);
    check_eq("pp_count_after", dut.u_fifo.count_q, 2);
    wait_idle(100, steps);
    check_eq("pp_cycles", steps, 8);
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("pp_order_%0d", i), log_at(lb + i), exp_t[i]);
    check_eq("pp_count_end", dut.u_fifo.count_q, 0);

    draw_n = 4;
    lb = log_q.size();
    push_req(4'd9, 4'd9, 3'd1);
    step(3);
    check_eq("ireq_in_send", mode, SEND);
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    check_eq("ireq_ignored", mode, SET);
    wait_idle(100, steps);
    check_eq("ireq_tile_cycles", steps, 6);
    req_valid = 1'b1; req_x = 4'd10; req_y = 4'd11; req_obj = 3'd6;
    step();
    req_valid = 1'b0;
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    check_eq("ireq_honoured", mode, SET_I);
    check_eq("ireq_no_load", log_q.size() - lb, 1);
    wait_idle(100, steps);
    check_eq("ireq_reinit_cycles", steps, 8);
    step(2);
    check_eq("ireq_after_mode", mode, SET);
    check_eq("ireq_after_xyo", {obj_code, Y, X}, tile(10, 11, 6));
    wait_idle(100, steps);

    push_req(4'd1, 4'd2, 3'd3);
    push_req(4'd4, 4'd5, 3'd6);
    step();
    check_eq("mid_pre_mode", mode, SET);
    nrst = 1'b0;
    step();
    check_eq("mid_mode", mode, NONE);
    check_eq("mid_csx", csx, 1);
    check_eq("mid_wrx", wrx, 1);
    check_eq("mid_busy", busy, 1);
    check_eq("mid_init_done", init_done, 0);
    check_eq("mid_xyo", {obj_code, Y, X}, 0);
    check_eq("mid_fifo_count", dut.u_fifo.count_q, 0);
    check_eq("mid_ready", req_ready, 1);
    nrst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
